rgmii_idelay_tuner: RTL
=======================

# rgmii_idelay_tuner

Runtime controller for the RGMII receive-path input delays. It replaces fixed per-design IDELAY tap values with a register-loaded value per channel, driving IDELAYE2 primitives in VAR_LOAD mode. It also provides an automatic eye-sweep mode that finds the best data tap from MAC frame statistics. It sits between the board Ethernet wrapper's IDELAYE2 instances, the MAC status pulses, and a software-visible command port.

## Interface

- CHANNELS, 5: delayed lines tuned together (4 rxd + rx_ctl); clock delay is not tuned here.
- TAP_DEFAULT, 25: tap loaded on every channel after reset (0..31).
- SETTLE_CYCLES, 64: idle cycles after each sweep load before measuring (≥1).
- FRAMES_PER_TAP, 16: frames observed per sweep tap (≥1).
- TIMEOUT_CYCLES, 2000000: maximum measurement cycles per tap (≥1).
- clock  in  1  IDELAY C clock and logic clock; must also drive C of every tuned IDELAYE2.
- reset_n  in  1  synchronous, active-low reset.
- ctrl_rdy  in  1  IDELAYCTRL RDY, asynchronous to clock; double-flop synchronised inside.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on cycle with cmd_valid & cmd_ready.
- cmd_op  in  2  0 = set one channel, 1 = set all channels, 2 = start sweep, 3 = ignored (accepted, no effect).
- cmd_chan  in  $clog2(CHANNELS)  target channel for op 0.
- cmd_tap  in  5  tap value for ops 0/1.
- good_frame  in  1  one-cycle pulse per good frame received (MAC rx_fifo_good_frame).
- bad_frame  in  1  one-cycle pulse per bad frame (rx_error_bad_frame | rx_error_bad_fcs).
- dly_cntvalue  out  5*CHANNELS  CNTVALUEIN per channel; channel i at [5i+4:5i].
- dly_ld  out  CHANNELS  per-channel LD strobe.
- tap_out  out  5*CHANNELS  committed tap per channel, same packing.
- busy  out  1  high outside IDLE.
- sweep_done  out  1  one-cycle pulse when a sweep ends (success or fail).
- sweep_fail  out  1  sticky; set when a sweep finds no passing tap or is aborted; cleared when the next sweep starts.

## Operation

- States: INIT_WAIT, IDLE, LOAD_SET, LOAD_STROBE, SW_LOAD, SW_STROBE, SW_SETTLE, SW_MEASURE, SW_FINAL.
- Reset: taps and dly_cntvalue = TAP_DEFAULT on all channels; dly_ld = 0; cmd_ready = 0; busy = 1; sweep_done = 0; sweep_fail = 0; state = INIT_WAIT.
- INIT_WAIT: when synchronised ctrl_rdy = 1, pulse dly_ld all-ones for one cycle, then go to IDLE.
- IDLE: cmd_ready = 1. Accepting op 0/1 goes to LOAD_SET, where the tap register(s) and dly_cntvalue are updated. LOAD_STROBE then pulses dly_ld for the affected channel(s), and the FSM returns to IDLE.
- op 0 with cmd_chan ≥ CHANNELS: accepted with no register change and no strobe.
- op 2: save all taps, clear sweep_fail, set t = 0, run = best = 0.
  - SW_LOAD: all channels get cntvalue t.
  - SW_STROBE: dly_ld all-ones.
  - SW_SETTLE: wait SETTLE_CYCLES; frame pulses are ignored here.
  - SW_MEASURE: count good and bad pulses; both pulses in the same cycle count both. Leave when good+bad ≥ FRAMES_PER_TAP or TIMEOUT_CYCLES elapse.
  - A tap passes iff bad = 0 and good ≥ FRAMES_PER_TAP; a timeout is a fail.
  - Track the longest contiguous passing run (start, len). On a tie, the earlier run is kept.
  - After t = 31, go to SW_FINAL.
- SW_FINAL:
  - If best len > 0: all taps = start + (len−1)/2 (integer division).
  - Otherwise: restore the saved taps and set sweep_fail.
  - Then load and strobe all channels and pulse sweep_done.
- ctrl_rdy falling (synchronised) in any state except INIT_WAIT:
  - Abort any sweep: restore saved taps, set sweep_fail, pulse sweep_done.
  - Go to INIT_WAIT, which reloads all channels when ready returns.
- Counters: frame counters saturate at FRAMES_PER_TAP; t is 6 bits internally so that 31 → 32 terminates the sweep without wrapping.

## Timing

- Commands at cycle T (handshake):
  - dly_cntvalue/tap_out update at T+1.
  - dly_ld high during T+2 only.
  - cmd_ready high again at T+3.
- cntvalue is stable from the cycle before the LD pulse until the next load, meeting the IDELAYE2 VAR_LOAD requirement.
- dly_ld is never high for two consecutive cycles. All outputs are registered.
- Sweep latency per tap: 2 + SETTLE_CYCLES + measurement cycles.
- ctrl_rdy is seen 2 cycles after its pad change.

## Test plan

- Reset with ctrl_rdy = 1: all dly_cntvalue = 25, one all-ones dly_ld pulse 3 cycles after reset release, then cmd_ready = 1.
- op 0, chan 2, tap 7: only channel 2 cntvalue becomes 7 at T+1, dly_ld = 5'b00100 at T+2 only; op 0 with chan 6 leaves all outputs unchanged.
- Sweep with model passing taps 10..20 and 24..26 (16 good frames each, bad otherwise): all taps end at 15, sweep_done pulses, sweep_fail = 0, exactly 33 all-channel LD pulses.
- Sweep with no frames at all: every tap times out, taps restored to pre-sweep values, sweep_fail = 1.
- Sweep with simultaneous good+bad pulses on tap 12 only: tap 12 fails; runs split correctly.
- ctrl_rdy dropped mid-SW_MEASURE: sweep_done pulse, sweep_fail = 1, busy held, full reload strobe after ctrl_rdy returns, saved taps restored.

Source files
------------

// File: rtl/rgmii_idelay_tuner_if.sv
// Command port of the RGMII IDELAY tuner.
//
// Handshake: the master holds cmd_valid and the payload (cmd_op, cmd_chan,
// cmd_tap) stable until a rising clock edge where cmd_valid and cmd_ready
// are both high; that edge transfers the command. cmd_ready never depends
// combinationally on cmd_valid.
interface rgmii_idelay_tuner_if #(
  parameter int CHANNELS = 5
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_chan;
  logic [4:0]    cmd_tap;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_chan,
    output cmd_tap,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_chan,
    input  cmd_tap,
    output cmd_ready
  );
endinterface

// File: rtl/rgmii_idelay_tuner.sv
// Runtime controller for RGMII receive IDELAYE2 taps (VAR_LOAD mode).
// Loads per-channel taps from a command port and runs an eye sweep that
// picks the centre of the longest run of taps with clean MAC frames.
module rgmii_idelay_tuner #(
  parameter int CHANNELS       = 5,
  parameter int TAP_DEFAULT    = 25,
  parameter int SETTLE_CYCLES  = 64,
  parameter int FRAMES_PER_TAP = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ctrl_rdy,
  rgmii_idelay_tuner_if.slave   cmd,
  input  logic                  good_frame,
  input  logic                  bad_frame,
  output logic [5*CHANNELS-1:0] dly_cntvalue,
  output logic [CHANNELS-1:0]   dly_ld,
  output logic [5*CHANNELS-1:0] tap_out,
  output logic                  busy,
  output logic                  sweep_done,
  output logic                  sweep_fail,
  output logic [3:0]            dbg_state
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = 5 * CHANNELS;
  localparam int FW = $clog2(FRAMES_PER_TAP + 1);
  localparam logic [FW-1:0] FRAMES_MAX   = FW'(FRAMES_PER_TAP);
  localparam logic [4:0]    TAP_RST      = 5'(TAP_DEFAULT);
  localparam logic [31:0]   SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    INIT_WAIT   = 4'd0,
    IDLE        = 4'd1,
    LOAD_SET    = 4'd2,
    LOAD_STROBE = 4'd3,
    SW_LOAD     = 4'd4,
    SW_STROBE   = 4'd5,
    SW_SETTLE   = 4'd6,
    SW_MEASURE  = 4'd7,
    SW_FINAL    = 4'd8
  } state_t;

  state_t state_q, state_d;

  // IDELAYCTRL ready synchroniser
  logic rdy_meta, rdy_sync;

  // Committed taps, taps saved at sweep start, and what the IDELAYs see
  logic [TW-1:0]       taps_q, taps_d;
  logic [TW-1:0]       saved_q, saved_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] ld_q, ld_d;

  logic cmd_ready_q, cmd_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fail_q, fail_d;

  // Sweep bookkeeping; t is one bit wider than a tap so 31 -> 32 ends the sweep
  logic [5:0]    t_q, t_d;
  logic [4:0]    run_start_q, run_start_d;
  logic [5:0]    run_len_q, run_len_d;
  logic [4:0]    best_start_q, best_start_d;
  logic [5:0]    best_len_q, best_len_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [FW-1:0] good_q, good_d;
  logic [FW-1:0] bad_q, bad_d;

  // Derived per-cycle conditions
  logic          accept;
  logic          abort;
  logic          in_sweep;
  logic [FW-1:0] good_sat, bad_sat;
  logic [FW:0]   frame_sum;
  logic          meas_done;
  logic          tap_pass;
  logic [5:0]    run_len_n;
  logic [4:0]    run_start_n;
  logic [4:0]    centre_tap;

  assign accept   = cmd.cmd_valid && cmd_ready_q && (state_q == IDLE);
  assign in_sweep = (state_q == SW_LOAD) || (state_q == SW_STROBE) ||
                    (state_q == SW_SETTLE) || (state_q == SW_MEASURE) ||
                    (state_q == SW_FINAL);
  // Losing IDELAYCTRL ready anywhere after init forces a full reload.
  assign abort    = !rdy_sync && (state_q != INIT_WAIT);

  // Frame counters including this cycle's pulses, saturating at the target
  assign good_sat  = (good_frame && (good_q < FRAMES_MAX)) ? good_q + 1'b1 : good_q;
  assign bad_sat   = (bad_frame && (bad_q < FRAMES_MAX)) ? bad_q + 1'b1 : bad_q;
  assign frame_sum = {1'b0, good_sat} + {1'b0, bad_sat};
  assign meas_done = (frame_sum >= {1'b0, FRAMES_MAX}) || (cyc_q == TIMEOUT_LAST);
  assign tap_pass  = (bad_sat == '0) && (good_sat >= FRAMES_MAX);

  // Passing-run tracking for the tap being closed out this cycle
  assign run_len_n   = tap_pass ? run_len_q + 6'd1 : 6'd0;
  assign run_start_n = (tap_pass && (run_len_q == 6'd0)) ? t_q[4:0] : run_start_q;
  assign centre_tap  = best_start_q + 5'((best_len_q - 6'd1) >> 1);

  // Two-flop synchroniser for the asynchronous IDELAYCTRL RDY
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
    end else begin
      rdy_meta <= ctrl_rdy;
      rdy_sync <= rdy_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= INIT_WAIT;
    else          state_q <= state_d;
  end

  // FSM next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_WAIT:   if (rdy_sync) state_d = LOAD_STROBE;
      IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            2'd0, 2'd1: state_d = LOAD_SET;
            2'd2:       state_d = SW_LOAD;
            default:    state_d = IDLE;
          endcase
        end
      end
      LOAD_SET:    state_d = LOAD_STROBE;
      LOAD_STROBE: state_d = IDLE;
      SW_LOAD:     state_d = SW_STROBE;
      SW_STROBE:   state_d = SW_SETTLE;
      SW_SETTLE:   if (cyc_q == SETTLE_LAST) state_d = SW_MEASURE;
      SW_MEASURE: begin
        if (meas_done) state_d = (t_q == 6'd31) ? SW_FINAL : SW_LOAD;
      end
      SW_FINAL:    state_d = LOAD_SET;
      default:     state_d = INIT_WAIT;
    endcase
    if (abort) state_d = INIT_WAIT;
  end

  // FSM output / datapath decode: next values of every registered output
  always_comb begin
    taps_d       = taps_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    ld_d         = '0;
    done_d       = 1'b0;
    fail_d       = fail_q;
    t_d          = t_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    cyc_d        = cyc_q;
    good_d       = good_q;
    bad_d        = bad_q;
    cmd_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);

    case (state_q)
      INIT_WAIT: begin
        // cntvalue already holds the committed taps; strobe them all in
        if (rdy_sync) ld_d = '1;
      end
      IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            2'd0: begin
              // Out-of-range channel matches nothing: empty mask, no change
              mask_d = '0;
              for (int i = 0; i < CHANNELS; i++) begin
                if (cmd.cmd_chan == CW'(i)) begin
                  taps_d[5*i +: 5] = cmd.cmd_tap;
                  mask_d[i]        = 1'b1;
                end
              end
              cnt_d = taps_d;
            end
            2'd1: begin
              taps_d = {CHANNELS{cmd.cmd_tap}};
              mask_d = '1;
              cnt_d  = taps_d;
            end
            2'd2: begin
              saved_d      = taps_q;
              fail_d       = 1'b0;
              t_d          = 6'd0;
              run_start_d  = 5'd0;
              run_len_d    = 6'd0;
              best_start_d = 5'd0;
              best_len_d   = 6'd0;
              cnt_d        = '0;
            end
            default: ;
          endcase
        end
      end
      LOAD_SET:    ld_d = mask_q;
      LOAD_STROBE: ;
      SW_LOAD:     ld_d = '1;
      SW_STROBE:   cyc_d = 32'd0;
      SW_SETTLE: begin
        // Frames during settling are ignored; counters start clean
        if (cyc_q == SETTLE_LAST) begin
          cyc_d  = 32'd0;
          good_d = '0;
          bad_d  = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      SW_MEASURE: begin
        good_d = good_sat;
        bad_d  = bad_sat;
        cyc_d  = cyc_q + 32'd1;
        if (meas_done) begin
          run_len_d   = run_len_n;
          run_start_d = run_start_n;
          // Strictly longer only, so an equal later run loses the tie
          if (run_len_n > best_len_q) begin
            best_len_d   = run_len_n;
            best_start_d = run_start_n;
          end
          t_d = t_q + 6'd1;
          if (t_q != 6'd31) cnt_d = {CHANNELS{t_d[4:0]}};
        end
      end
      SW_FINAL: begin
        if (best_len_q != 6'd0) begin
          taps_d = {CHANNELS{centre_tap}};
        end else begin
          taps_d = saved_q;
          fail_d = 1'b1;
        end
        cnt_d  = taps_d;
        mask_d = '1;
        done_d = 1'b1;
      end
      default: ;
    endcase

    if (abort) begin
      ld_d = '0;
      if (in_sweep) begin
        taps_d = saved_q;
        fail_d = 1'b1;
        done_d = 1'b1;
      end else begin
        taps_d = taps_q;
      end
      cnt_d = taps_d;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      taps_q       <= {CHANNELS{TAP_RST}};
      saved_q      <= {CHANNELS{TAP_RST}};
      cnt_q        <= {CHANNELS{TAP_RST}};
      mask_q       <= '0;
      ld_q         <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      t_q          <= 6'd0;
      run_start_q  <= 5'd0;
      run_len_q    <= 6'd0;
      best_start_q <= 5'd0;
      best_len_q   <= 6'd0;
      cyc_q        <= 32'd0;
      good_q       <= '0;
      bad_q        <= '0;
    end else begin
      taps_q       <= taps_d;
      saved_q      <= saved_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      ld_q         <= ld_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      t_q          <= t_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      cyc_q        <= cyc_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign dly_cntvalue  = cnt_q;
  assign dly_ld        = ld_q;
  assign tap_out       = taps_q;
  assign busy          = busy_q;
  assign sweep_done    = done_q;
  assign sweep_fail    = fail_q;
  assign dbg_state     = state_q;

endmodule
